// File: rtl/ask_deserializer.sv
// Oversampling receiver for the demodulated ASK line: start bit, DATA_BITS payload
// bits LSB first, one stop bit. Emits each good word with a single-cycle strobe.
module ask_deserializer #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 10,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] word,
    output logic                 word_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             START_LEVEL = ~IDLE_LEVEL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 line_s;
    logic                 line_d;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;

    // Two-flop synchronizer plus a delayed copy for start-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= IDLE_LEVEL;
            line_s <= IDLE_LEVEL;
            line_d <= IDLE_LEVEL;
        end else begin
            sync1  <= serial_in;
            line_s <= sync1;
            line_d <= line_s;
        end
    end

    // Framing FSM; every sample is taken at a counter expiry near bit centre
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (line_d == IDLE_LEVEL && line_s != IDLE_LEVEL) begin
                        state <= S_START;
                        cnt   <= HALF_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (line_s == START_LEVEL) begin
                        state <= S_DATA;
                        idx   <= '0;
                        cnt   <= FULL_LOAD;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        shreg[idx] <= line_s;
                        cnt        <= FULL_LOAD;
                        if (idx == LAST_IDX) begin
                            state <= S_STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        busy <= 1'b0;
                        if (line_s == IDLE_LEVEL) begin
                            word       <= shreg;
                            word_valid <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    // A line stuck at the start level must not retrigger framing
                    if (line_s == IDLE_LEVEL) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
